aip_config_register_bank: RTL and testbench

Parametrised successor to the AIP configuration register block. It is the host-writable configuration bank between the AIP host write bus and the IP core.
- N byte-writable shadow registers, committed atomically to an active set only when the core reports idle.
- The streaming register is replaced by a first-word-fall-through (FWFT) FIFO with a ready/valid output and sticky overflow.
- Single clock domain: host writes and core consumption both run on writeClock.

---
 rtl/aip_config_register_bank_pkg.sv | 26 ++
 rtl/aip_config_register_bank_if.sv | 40 ++++
 rtl/aip_config_register_bank_fifo.sv | 62 ++++++
 rtl/aip_config_register_bank.sv | 129 ++++++++++++
 tb/tb_aip_config_register_bank.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/aip_config_register_bank_pkg.sv
// Purpose: shared constants, commit FSM encoding and address map helpers for the AIP config bank.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package aip_config_pkg;

  // Control register bit positions (control address = REGISTERS+1)
  localparam int CTRL_COMMIT = 0;
  localparam int CTRL_FLUSH  = 1;

  // Commit FSM: waiting for a commit request, or holding one until the core goes idle
  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } commit_state_t;

  // The stream push port sits directly after the last config register
  function automatic int stream_address(input int registers);
    return registers;
  endfunction

  // The control port sits directly after the stream push port
  function automatic int control_address(input int registers);
    return registers + 1;
  endfunction

endpackage

// File: rtl/aip_config_register_bank_if.sv
// Purpose: host write bus plus core-side config/stream signals of the AIP config bank.
// Latency: none (wiring only).
// Backpressure: stream side is ready/valid; host writes are never stalled.
interface aip_config_register_bank_if #(
  parameter int DATAWIDTH   = 32,
  parameter int REGISTERS   = 8,
  parameter int STREAMDEPTH = 4
);
  localparam int ADDRWIDTH  = $clog2(REGISTERS + 2);
  localparam int LEVELWIDTH = $clog2(STREAMDEPTH + 1);

  logic                           writeEnable;
  logic [ADDRWIDTH-1:0]           writeAddress;
  logic [DATAWIDTH/8-1:0]         writeStrobe;
  logic [DATAWIDTH-1:0]           dataInput;
  logic [REGISTERS*DATAWIDTH-1:0] configOut;
  logic                           coreIdle;
  logic                           commitPending;
  logic                           commitDone;
  logic [DATAWIDTH-1:0]           streamData;
  logic                           streamValid;
  logic                           streamReady;
  logic [LEVELWIDTH-1:0]          streamLevel;
  logic                           streamOverflow;

  // Host / core side: drives writes, idle and ready; observes everything else
  modport master (
    output writeEnable, writeAddress, writeStrobe, dataInput, coreIdle, streamReady,
    input  configOut, commitPending, commitDone, streamData, streamValid, streamLevel,
           streamOverflow
  );

  // Register bank side
  modport slave (
    input  writeEnable, writeAddress, writeStrobe, dataInput, coreIdle, streamReady,
    output configOut, commitPending, commitDone, streamData, streamValid, streamLevel,
           streamOverflow
  );

endinterface

// File: rtl/aip_config_register_bank_fifo.sv
// Purpose: generic first-word-fall-through FIFO with synchronous flush and occupancy count.
// Latency: pushed word is visible on headData one cycle after the push edge (no bypass).
// Backpressure: push ignored when full unless a pop happens the same cycle; pop ignored when empty.
module aip_stream_fifo #(
  parameter int DATAWIDTH   = 32,
  parameter int STREAMDEPTH = 4
) (
  input  logic                               writeClock,
  input  logic                               reset,
  input  logic                               push,
  input  logic [DATAWIDTH-1:0]               pushData,
  input  logic                               pop,
  input  logic                               flush,
  output logic [DATAWIDTH-1:0]               headData,
  output logic                               notEmpty,
  output logic                               full,
  output logic [$clog2(STREAMDEPTH+1)-1:0]   level
);
  localparam int PTRWIDTH   = $clog2(STREAMDEPTH);
  localparam int LEVELWIDTH = $clog2(STREAMDEPTH + 1);

  logic [DATAWIDTH-1:0]  storage [STREAMDEPTH];
  logic [PTRWIDTH-1:0]   readPtr;
  logic [PTRWIDTH-1:0]   writePtr;
  logic [LEVELWIDTH-1:0] count;
  logic                  doPush;
  logic                  doPop;

  // Qualify requests: a full FIFO still accepts a push when the head leaves the same cycle
  always_comb begin
    full     = (count == LEVELWIDTH'(STREAMDEPTH));
    notEmpty = (count != '0);
    doPop    = pop && notEmpty;
    doPush   = push && (!full || doPop);
    headData = storage[readPtr];
    level    = count;
  end

  // Pointers wrap naturally because the depth is a power of two; flush wins over push/pop
  always_ff @(posedge writeClock or negedge reset) begin
    if (!reset) begin
      readPtr  <= '0;
      writePtr <= '0;
      count    <= '0;
    end else if (flush) begin
      readPtr  <= '0;
      writePtr <= '0;
      count    <= '0;
    end else begin
      if (doPush) writePtr <= writePtr + 1'b1;
      if (doPop)  readPtr  <= readPtr + 1'b1;
      if (doPush && !doPop)      count <= count + 1'b1;
      else if (doPop && !doPush) count <= count - 1'b1;
    end
  end

  // Data storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge writeClock) begin
    if (doPush && !flush) storage[writePtr] <= pushData;
  end

endmodule

// File: rtl/aip_config_register_bank.sv
// Purpose: byte-writable shadow config registers committed atomically to an active set, plus stream FIFO.
// Latency: commit applies at the first edge with coreIdle after the request (earliest one edge after the control write).
// Backpressure: stream pushes dropped when full with no pop (sticky overflow); commits wait for coreIdle.
module aip_config_register_bank
  import aip_config_pkg::*;
#(
  parameter int DATAWIDTH   = 32,
  parameter int REGISTERS   = 8,
  parameter int STREAMDEPTH = 4
) (
  input  logic                       writeClock,
  input  logic                       reset,
  aip_config_register_bank_if.slave  bus
);
  localparam int ADDRWIDTH = $clog2(REGISTERS + 2);
  localparam int BYTES     = DATAWIDTH / 8;
  localparam logic [ADDRWIDTH-1:0] STREAMADDR = ADDRWIDTH'(stream_address(REGISTERS));
  localparam logic [ADDRWIDTH-1:0] CTRLADDR   = ADDRWIDTH'(control_address(REGISTERS));

  logic [DATAWIDTH-1:0] shadow [REGISTERS];
  logic [DATAWIDTH-1:0] active [REGISTERS];

  logic          cfgWrite;
  logic          streamPush;
  logic          ctrlWrite;
  logic          commitRequest;
  logic          flushRequest;
  logic          streamPop;
  logic          fifoFull;
  logic          transfer;
  logic          doneQ;
  logic          overflowQ;
  commit_state_t state;
  commit_state_t nextState;

  // Address decode; anything above the control address falls through all three and is ignored
  always_comb begin
    cfgWrite      = bus.writeEnable && (bus.writeAddress < STREAMADDR);
    streamPush    = bus.writeEnable && (bus.writeAddress == STREAMADDR);
    ctrlWrite     = bus.writeEnable && (bus.writeAddress == CTRLADDR);
    commitRequest = ctrlWrite && bus.dataInput[CTRL_COMMIT];
    flushRequest  = ctrlWrite && bus.dataInput[CTRL_FLUSH];
    streamPop     = bus.streamValid && bus.streamReady;
  end

  // Shadow registers take host writes byte by byte under the strobe mask
  always_ff @(posedge writeClock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REGISTERS; i++) shadow[i] <= '0;
    end else if (cfgWrite) begin
      for (int i = 0; i < REGISTERS; i++) begin
        for (int k = 0; k < BYTES; k++) begin
          if (bus.writeAddress == ADDRWIDTH'(i) && bus.writeStrobe[k])
            shadow[i][k*8 +: 8] <= bus.dataInput[k*8 +: 8];
        end
      end
    end
  end

  // Active set copies the whole shadow at once; a same-edge shadow write is not seen here
  always_ff @(posedge writeClock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REGISTERS; i++) active[i] <= '0;
    end else if (transfer) begin
      for (int i = 0; i < REGISTERS; i++) active[i] <= shadow[i];
    end
  end

  // Flatten the active set onto the core-facing bus
  always_comb begin
    bus.configOut = '0;
    for (int i = 0; i < REGISTERS; i++) bus.configOut[i*DATAWIDTH +: DATAWIDTH] = active[i];
  end

  // Commit FSM state register
  always_ff @(posedge writeClock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // Commit FSM next state: a new request always (re-)arms, even on the transfer edge
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (commitRequest) nextState = PENDING;
      PENDING: if (bus.coreIdle && !commitRequest) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Commit FSM outputs
  always_comb begin
    transfer          = (state == PENDING) && bus.coreIdle;
    bus.commitPending = (state == PENDING);
    bus.commitDone    = doneQ;
  end

  // One-cycle done pulse following each transfer edge
  always_ff @(posedge writeClock or negedge reset) begin
    if (!reset) doneQ <= 1'b0;
    else        doneQ <= transfer;
  end

  // Sticky overflow: set by a dropped push, cleared only by flush (flush wins)
  always_ff @(posedge writeClock or negedge reset) begin
    if (!reset)                                  overflowQ <= 1'b0;
    else if (flushRequest)                       overflowQ <= 1'b0;
    else if (streamPush && fifoFull && !streamPop) overflowQ <= 1'b1;
  end

  assign bus.streamOverflow = overflowQ;

  aip_stream_fifo #(
    .DATAWIDTH   (DATAWIDTH),
    .STREAMDEPTH (STREAMDEPTH)
  ) u_stream_fifo (
    .writeClock (writeClock),
    .reset      (reset),
    .push       (streamPush),
    .pushData   (bus.dataInput),
    .pop        (bus.streamReady),
    .flush      (flushRequest),
    .headData   (bus.streamData),
    .notEmpty   (bus.streamValid),
    .full       (fifoFull),
    .level      (bus.streamLevel)
  );

endmodule

// File: tb/tb_aip_config_register_bank.sv
// Purpose: directed plus randomized bench for aip_config_register_bank against a queue/array model.
// Latency: model advances one step per rising edge; outputs sampled 1 time unit after the edge.
// Backpressure: streamReady and coreIdle are driven by the bench (directed, then random).
module tb_aip_config_register_bank;
  import aip_config_pkg::*;

  localparam int DW    = 32;
  localparam int REG   = 8;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(REG + 2);
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int SADDR = REG;
  localparam int CADDR = REG + 1;

  logic writeClock;
  logic reset;

  aip_config_register_bank_if #(.DATAWIDTH(DW), .REGISTERS(REG), .STREAMDEPTH(DEPTH)) bus ();

  aip_config_register_bank #(.DATAWIDTH(DW), .REGISTERS(REG), .STREAMDEPTH(DEPTH)) dut (
    .writeClock (writeClock),
    .reset      (reset),
    .bus        (bus)
  );

  initial writeClock = 1'b0;
  always #5 writeClock = ~writeClock;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  // Behavioural reference model
  logic [DW-1:0] mShadow [REG];
  logic [DW-1:0] mActive [REG];
  logic [DW-1:0] mq [$];
  bit            mPending;
  bit            mDone;
  bit            mOvf;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] exp_cfg();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < REG; i++) r[i*DW +: DW] = mActive[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < REG; i++) begin
      mShadow[i] = '0;
      mActive[i] = '0;
    end
    mq.delete();
    mPending = 0;
    mDone    = 0;
    mOvf     = 0;
  endtask

  // One edge of the specified behaviour, from the inputs currently on the bus
  task automatic model_step();
    int  a;
    int  sz;
    bit  we, pop, push, flush, commit, xfer;
    a      = int'(bus.writeAddress);
    we     = bus.writeEnable;
    sz     = mq.size();
    pop    = (sz > 0) && bus.streamReady;
    push   = we && (a == SADDR);
    commit = we && (a == CADDR) && bus.dataInput[CTRL_COMMIT];
    flush  = we && (a == CADDR) && bus.dataInput[CTRL_FLUSH];
    xfer   = mPending && bus.coreIdle;
    if (xfer) begin
      for (int i = 0; i < REG; i++) mActive[i] = mShadow[i];
    end
    if (we && a < REG) begin
      for (int k = 0; k < DW/8; k++)
        if (bus.writeStrobe[k]) mShadow[a][k*8 +: 8] = bus.dataInput[k*8 +: 8];
    end
    mDone = xfer;
    if (commit)    mPending = 1;
    else if (xfer) mPending = 0;
    if (flush) begin
      mq.delete();
      mOvf = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (sz < DEPTH || pop) mq.push_back(bus.dataInput);
        else                   mOvf = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/configOut"}, bus.configOut, exp_cfg());
    chk({tag, "/commitPending"}, 256'(bus.commitPending), 256'(mPending));
    chk({tag, "/commitDone"}, 256'(bus.commitDone), 256'(mDone));
    chk({tag, "/streamValid"}, 256'(bus.streamValid), 256'(mq.size() > 0));
    chk({tag, "/streamLevel"}, 256'(bus.streamLevel), 256'(mq.size()));
    chk({tag, "/streamOverflow"}, 256'(bus.streamOverflow), 256'(mOvf));
    if (mq.size() > 0) chk({tag, "/streamData"}, 256'(bus.streamData), 256'(mq[0]));
  endtask

  task automatic cycle(input string tag);
    @(posedge writeClock);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic wr(input int a, input logic [3:0] s, input logic [DW-1:0] d, input string tag);
    bus.writeEnable  = 1'b1;
    bus.writeAddress = AW'(a);
    bus.writeStrobe  = s;
    bus.dataInput    = d;
    cycle(tag);
    bus.writeEnable  = 1'b0;
  endtask

  task automatic drain(input logic [DW-1:0] v, input string tag);
    bus.streamReady = 1'b1;
    chk({tag, "/head"}, 256'(bus.streamData), 256'(v));
    cycle(tag);
    bus.streamReady = 1'b0;
  endtask

  initial begin
    int a;
    int r;
    reset            = 1'b0;
    bus.writeEnable  = 1'b0;
    bus.writeAddress = '0;
    bus.writeStrobe  = '0;
    bus.dataInput    = '0;
    bus.coreIdle     = 1'b0;
    bus.streamReady  = 1'b0;
    model_reset();
    #2;
    check_all("por");
    @(negedge writeClock);
    reset = 1'b1;

    // Reset discards committed config, pending commit and stream contents
    bus.coreIdle = 1'b1;
    wr(0, 4'hF, 32'hDEADBEEF, "rst_wr0");
    wr(CADDR, 4'h0, 32'h1, "rst_commit");
    cycle("rst_xfer");
    chk("rst_pre_cfg0", 256'(bus.configOut[31:0]), 256'(32'hDEADBEEF));
    wr(CADDR, 4'h0, 32'h1, "rst_commit2");
    wr(SADDR, 4'h0, 32'h7, "rst_push");
    @(negedge writeClock);
    reset = 1'b0;
    model_reset();
    #1;
    check_all("in_reset");
    chk("rst_cfg", bus.configOut, 256'h0);
    chk("rst_valid", 256'(bus.streamValid), 256'(0));
    chk("rst_pending", 256'(bus.commitPending), 256'(0));
    @(negedge writeClock);
    reset = 1'b1;
    cycle("post_reset");

    // Byte strobes and minimum-latency commit
    wr(2, 4'hF, 32'h11223344, "bs_full");
    wr(2, 4'h5, 32'hAABBCCDD, "bs_partial");
    wr(CADDR, 4'h0, 32'h1, "bs_commit");
    chk("bs_before_xfer", 256'(bus.configOut[2*DW +: DW]), 256'(0));
    cycle("bs_xfer");
    chk("bs_reg2", 256'(bus.configOut[2*DW +: DW]), 256'(32'h11BB33DD));
    chk("bs_done_hi", 256'(bus.commitDone), 256'(1));
    cycle("bs_after");
    chk("bs_done_lo", 256'(bus.commitDone), 256'(0));

    // Deferred commit, with a shadow write on the transfer edge
    bus.coreIdle = 1'b0;
    wr(2, 4'hF, 32'hCAFEF00D, "df_wr");
    wr(CADDR, 4'h0, 32'h1, "df_commit");
    for (int i = 0; i < 10; i++) cycle("df_wait");
    chk("df_pending", 256'(bus.commitPending), 256'(1));
    chk("df_unchanged", 256'(bus.configOut[2*DW +: DW]), 256'(32'h11BB33DD));
    bus.coreIdle = 1'b1;
    wr(2, 4'hF, 32'h55667788, "df_xfer_wr");
    chk("df_old_value", 256'(bus.configOut[2*DW +: DW]), 256'(32'hCAFEF00D));
    chk("df_done", 256'(bus.commitDone), 256'(1));
    cycle("df_after");
    wr(CADDR, 4'h0, 32'h1, "df_commit2");
    cycle("df_xfer2");
    chk("df_new_value", 256'(bus.configOut[2*DW +: DW]), 256'(32'h55667788));

    // Fill past full, then drain in order
    bus.coreIdle = 1'b0;
    for (int v = 1; v <= 5; v++) wr(SADDR, 4'h0, DW'(v), "ff_push");
    chk("ff_level", 256'(bus.streamLevel), 256'(4));
    chk("ff_ovf", 256'(bus.streamOverflow), 256'(1));
    for (int v = 1; v <= 4; v++) drain(DW'(v), "ff_drain");
    chk("ff_empty", 256'(bus.streamValid), 256'(0));

    // Push into a full FIFO alongside a pop
    wr(CADDR, 4'h0, 32'h2, "fp_flush");
    for (int v = 1; v <= 4; v++) wr(SADDR, 4'h0, DW'(v), "fp_fill");
    bus.streamReady = 1'b1;
    wr(SADDR, 4'h0, 32'h9, "fp_pushpop");
    bus.streamReady = 1'b0;
    chk("fp_ovf", 256'(bus.streamOverflow), 256'(0));
    chk("fp_level", 256'(bus.streamLevel), 256'(4));
    drain(32'h2, "fp_d2");
    drain(32'h3, "fp_d3");
    drain(32'h4, "fp_d4");
    drain(32'h9, "fp_d9");

    // Flush with a same-cycle pop
    for (int v = 1; v <= 5; v++) wr(SADDR, 4'h0, DW'(v + 16), "fl_fill");
    drain(32'h11, "fl_pop");
    chk("fl_level3", 256'(bus.streamLevel), 256'(3));
    bus.streamReady = 1'b1;
    wr(CADDR, 4'h0, 32'h2, "fl_flush");
    bus.streamReady = 1'b0;
    chk("fl_level0", 256'(bus.streamLevel), 256'(0));
    chk("fl_ovf0", 256'(bus.streamOverflow), 256'(0));
    chk("fl_valid0", 256'(bus.streamValid), 256'(0));

    // Randomized traffic across all address regions including unused ones
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4)      a = int'($urandom_range(0, REG - 1));
      else if (r < 7) a = SADDR;
      else if (r < 9) a = CADDR;
      else            a = int'($urandom_range(CADDR + 1, (1 << AW) - 1));
      bus.writeEnable  = ($urandom_range(0, 3) != 0);
      bus.writeAddress = AW'(a);
      bus.writeStrobe  = 4'($urandom);
      bus.dataInput    = $urandom;
      if (a == CADDR) bus.dataInput[CTRL_FLUSH] = ($urandom_range(0, 7) == 0);
      bus.coreIdle     = ($urandom_range(0, 3) == 0);
      bus.streamReady  = ($urandom_range(0, 2) == 0);
      cycle("rand");
    end
    bus.writeEnable = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
